dma_s2mm_writer: RTL and testbench

Stream-to-memory DMA channel. It accepts FIR output samples on an AXI-Stream slave port and writes them as 32-bit words into SDRAM through a Wishbone master port that connects to the bus arbiter. It is the write-back counterpart of the existing memory-to-stream DMA path, which feeds ss_tdata. A small FIFO decouples stream arrival from Wishbone/SDRAM latency.

---
 rtl/dma_s2mm_writer.sv | 174 +++++++++++++++++
 tb/tb_dma_s2mm_writer.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_s2mm_writer.sv
// Stream-to-memory DMA channel: accepts 32-bit samples on an AXI-Stream slave,
// buffers them in a small circular FIFO and writes them as single Wishbone
// write cycles to consecutive word addresses starting at a programmed base.
module dma_s2mm_writer #(
   parameter int FIFO_DEPTH = 4,
   parameter int LEN_W      = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cfg_start,
   input  logic [31:0]      cfg_base_addr,
   input  logic [LEN_W-1:0] cfg_len,
   output logic             cfg_busy,
   output logic             cfg_done,
   output logic             err_len,
   input  logic             s_tvalid,
   input  logic [31:0]      s_tdata,
   input  logic             s_tlast,
   output logic             s_tready,
   output logic             wbm_cyc_o,
   output logic             wbm_stb_o,
   output logic             wbm_we_o,
   output logic [3:0]       wbm_sel_o,
   output logic [31:0]      wbm_adr_o,
   output logic [31:0]      wbm_dat_o,
   input  logic             wbm_ack_i
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t state_q, state_d;

   // Transfer bookkeeping
   logic [31:0]      base_q;
   logic [LEN_W-1:0] len_q;
   logic [LEN_W-1:0] acc_cnt_q;
   logic [LEN_W-1:0] wr_cnt_q;
   logic             err_q;

   // Sample FIFO
   logic [31:0]      fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [CNT_W-1:0] fifo_cnt_q;

   // Wishbone master registers
   logic             wb_active_q;
   logic [31:0]      adr_q;
   logic [31:0]      dat_q;

   logic start_ok;
   logic fifo_full;
   logic fifo_empty;
   logic push;
   logic pop;
   logic ack_fire;
   logic last_write;
   logic issue;
   logic beat_is_len;

   assign start_ok    = (state_q == IDLE) && cfg_start;
   assign fifo_full   = (fifo_cnt_q == CNT_W'(FIFO_DEPTH));
   assign fifo_empty  = (fifo_cnt_q == '0);
   // Ready depends on registered state only; a pop this cycle does not open a slot.
   assign s_tready    = (state_q == RUN) && !fifo_full && (acc_cnt_q < len_q);
   assign push        = s_tvalid && s_tready;
   assign ack_fire    = wb_active_q && wbm_ack_i;
   assign pop         = ack_fire;
   assign beat_is_len = ((acc_cnt_q + LEN_W'(1)) == len_q);
   assign last_write  = ack_fire && ((wr_cnt_q + LEN_W'(1)) == len_q);
   // A new cycle starts only from an idle bus, which guarantees a gap after each ack.
   assign issue       = (state_q == RUN) && !fifo_empty && !wb_active_q;

   assign cfg_busy  = (state_q == RUN);
   assign cfg_done  = (state_q == DONE);
   assign err_len   = err_q;
   assign wbm_cyc_o = wb_active_q;
   assign wbm_stb_o = wb_active_q;
   assign wbm_we_o  = wb_active_q;
   assign wbm_sel_o = {4{wb_active_q}};
   assign wbm_adr_o = adr_q;
   assign wbm_dat_o = dat_q;

   // State register
   always_ff @(posedge clk) begin
      // NOTE: registers use <= so every flop samples pre-edge values, independent of block order.
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic: a zero-length start goes straight to DONE
   always_comb begin
      // NOTE: default assigned first so no path leaves state_d unassigned (no latch).
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (cfg_start) state_d = (cfg_len == '0) ? DONE : RUN;
         RUN:     if (last_write) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Transfer parameters, beat/write counters and the sticky length error
   always_ff @(posedge clk) begin
      if (rst) begin
         base_q    <= '0;
         len_q     <= '0;
         acc_cnt_q <= '0;
         wr_cnt_q  <= '0;
         err_q     <= 1'b0;
      end else if (start_ok) begin
         base_q    <= cfg_base_addr & 32'hFFFF_FFFC;
         len_q     <= cfg_len;
         acc_cnt_q <= '0;
         wr_cnt_q  <= '0;
         err_q     <= 1'b0;
      end else begin
         if (push) begin
            acc_cnt_q <= acc_cnt_q + LEN_W'(1);
            // tlast must coincide exactly with the len-th beat; either mismatch flags
            if (s_tlast != beat_is_len) err_q <= 1'b1;
         end
         if (pop) wr_cnt_q <= wr_cnt_q + LEN_W'(1);
      end
   end

   // FIFO storage
   always_ff @(posedge clk) begin
      // NOTE: storage array is not reset; pointers and count alone define valid entries.
      if (push) fifo_mem[wr_ptr_q] <= s_tdata;
   end

   // FIFO pointers and occupancy; flushed on every accepted start
   always_ff @(posedge clk) begin
      if (rst || start_ok) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         fifo_cnt_q <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         unique case ({push, pop})
            2'b10:   fifo_cnt_q <= fifo_cnt_q + CNT_W'(1);
            2'b01:   fifo_cnt_q <= fifo_cnt_q - CNT_W'(1);
            default: fifo_cnt_q <= fifo_cnt_q;
         endcase
      end
   end

   // Wishbone master: one single write outstanding, fields held until ack
   always_ff @(posedge clk) begin
      if (rst) begin
         wb_active_q <= 1'b0;
         adr_q       <= '0;
         dat_q       <= '0;
      end else if (issue) begin
         wb_active_q <= 1'b1;
         adr_q       <= base_q + 32'({wr_cnt_q, 2'b00});
         dat_q       <= fifo_mem[rd_ptr_q];
      end else if (ack_fire) begin
         wb_active_q <= 1'b0;
         adr_q       <= '0;
         dat_q       <= '0;
      end
   end

endmodule

// File: tb/tb_dma_s2mm_writer.sv
// Directed testbench for dma_s2mm_writer: a Wishbone slave responder with a
// programmable ack delay records every write; the main sequence drives the
// stream and configuration ports and compares against hand-derived values.
module tb_dma_s2mm_writer;

   localparam int LEN_W  = 16;
   localparam int BUDGET = 200;

   logic             clk = 1'b0;
   logic             rst;
   logic             cfg_start;
   logic [31:0]      cfg_base_addr;
   logic [LEN_W-1:0] cfg_len;
   logic             cfg_busy;
   logic             cfg_done;
   logic             err_len;
   logic             s_tvalid;
   logic [31:0]      s_tdata;
   logic             s_tlast;
   logic             s_tready;
   logic             wbm_cyc_o;
   logic             wbm_stb_o;
   logic             wbm_we_o;
   logic [3:0]       wbm_sel_o;
   logic [31:0]      wbm_adr_o;
   logic [31:0]      wbm_dat_o;
   logic             ack_r;
   logic             ack_man;
   wire              wbm_ack_i = ack_r | ack_man;

   int  total = 0;
   int  bad   = 0;
   int  ack_delay = 1;
   bit  ack_en = 1'b1;
   time last_ack_t = 0;
   time done_t;

   logic [31:0] wr_adr_q[$];
   logic [31:0] wr_dat_q[$];
   logic        wr_ok_q[$];
   logic [31:0] exp_dat_q[$];

   always #5 clk = ~clk;

   dma_s2mm_writer #(.FIFO_DEPTH(4), .LEN_W(LEN_W)) dut (
      .clk           (clk),
      .rst           (rst),
      .cfg_start     (cfg_start),
      .cfg_base_addr (cfg_base_addr),
      .cfg_len       (cfg_len),
      .cfg_busy      (cfg_busy),
      .cfg_done      (cfg_done),
      .err_len       (err_len),
      .s_tvalid      (s_tvalid),
      .s_tdata       (s_tdata),
      .s_tlast       (s_tlast),
      .s_tready      (s_tready),
      .wbm_cyc_o     (wbm_cyc_o),
      .wbm_stb_o     (wbm_stb_o),
      .wbm_we_o      (wbm_we_o),
      .wbm_sel_o     (wbm_sel_o),
      .wbm_adr_o     (wbm_adr_o),
      .wbm_dat_o     (wbm_dat_o),
      .wbm_ack_i     (wbm_ack_i)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Every control output and bus field must be zero
   task automatic check_quiet(input string tag);
      check({tag, "_ctl"}, 64'({cfg_busy, cfg_done, err_len, s_tready,
                                wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o}), 64'd0);
      check({tag, "_bus"}, {wbm_adr_o, wbm_dat_o}, 64'd0);
   endtask

   // Pulse cfg_start for one cycle; returns in the cycle after the start edge
   task automatic start(input logic [31:0] b, input logic [LEN_W-1:0] l);
      cfg_base_addr = b;
      cfg_len       = l;
      cfg_start     = 1'b1;
      @(posedge clk); #1;
      cfg_start     = 1'b0;
   endtask

   // Offer one beat and wait (bounded) for the handshake edge
   task automatic send_beat(input logic [31:0] d, input logic last);
      int n = 0;
      s_tvalid = 1'b1;
      s_tdata  = d;
      s_tlast  = last;
      while (!s_tready && n < BUDGET) begin
         @(posedge clk); #1;
         n++;
      end
      check("beat_wait", 64'(n < BUDGET), 64'd1);
      @(posedge clk); #1;
      exp_dat_q.push_back(d);
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
   endtask

   task automatic wait_done(input string tag, output time t);
      int n = 0;
      while (!cfg_done && n < BUDGET) begin
         @(posedge clk); #1;
         n++;
      end
      check({tag, "_done_seen"}, 64'(cfg_done), 64'd1);
      t = $time;
   endtask

   // Compare recorded writes with consecutive word addresses and sent data
   task automatic check_writes(input string tag, input logic [31:0] base, input int n);
      logic [31:0] ea;
      check({tag, "_nwrites"}, 64'(wr_adr_q.size()), 64'(n));
      for (int i = 0; i < n && wr_adr_q.size() > 0 && exp_dat_q.size() > 0; i++) begin
         ea = base + 32'(i * 4);
         check({tag, "_adr"}, 64'(wr_adr_q.pop_front()), 64'(ea));
         check({tag, "_dat"}, 64'(wr_dat_q.pop_front()), 64'(exp_dat_q.pop_front()));
         check({tag, "_we_sel"}, 64'(wr_ok_q.pop_front()), 64'd1);
      end
      wr_adr_q.delete();
      wr_dat_q.delete();
      wr_ok_q.delete();
      exp_dat_q.delete();
   endtask

   // Wishbone slave: records each write, checks hold-stability, acks after ack_delay cycles
   initial begin : responder
      logic [31:0] a;
      logic [31:0] d;
      ack_r = 1'b0;
      forever begin
         @(posedge clk); #1;
         if (ack_en && wbm_cyc_o && wbm_stb_o) begin
            a = wbm_adr_o;
            d = wbm_dat_o;
            wr_adr_q.push_back(a);
            wr_dat_q.push_back(d);
            wr_ok_q.push_back(wbm_we_o && (wbm_sel_o == 4'hF));
            repeat (ack_delay) @(posedge clk);
            #1;
            check("wb_hold_fields", {wbm_adr_o, wbm_dat_o}, {a, d});
            check("wb_hold_stb", 64'(wbm_stb_o), 64'd1);
            ack_r = 1'b1;
            @(posedge clk);
            last_ack_t = $time;
            #1 ack_r = 1'b0;
         end
      end
   end

   initial begin : main
      rst           = 1'b1;
      cfg_start     = 1'b0;
      cfg_base_addr = '0;
      cfg_len       = '0;
      s_tvalid      = 1'b0;
      s_tdata       = '0;
      s_tlast       = 1'b0;
      ack_man       = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_quiet("reset");
      rst = 1'b0;
      @(posedge clk); #1;

      // 1: four words, ack one cycle after stb
      start(32'h3800_0000, 16'd4);
      check("t1_busy", 64'(cfg_busy), 64'd1);
      send_beat(32'h11, 1'b0);
      check("t1_stb_t1", 64'(wbm_stb_o), 64'd0);
      @(posedge clk); #1;
      check("t1_stb_t2", 64'(wbm_stb_o), 64'd1);
      send_beat(32'h22, 1'b0);
      send_beat(32'h33, 1'b0);
      send_beat(32'h44, 1'b1);
      wait_done("t1", done_t);
      check("t1_done_after_ack", 64'(done_t - last_ack_t), 64'd1);
      check("t1_busy_fall", 64'(cfg_busy), 64'd0);
      check("t1_err", 64'(err_len), 64'd0);
      @(posedge clk); #1;
      check("t1_done_width", 64'(cfg_done), 64'd0);
      check_writes("t1", 32'h3800_0000, 4);

      // 2: eight words, continuous valid, slow acks fill the FIFO
      ack_delay = 5;
      start(32'h0000_0100, 16'd8);
      for (int i = 0; i < 8; i++) begin
         send_beat(32'h200 + 32'(i), (i == 7));
         if (i == 3) check("t2_full_tready", 64'(s_tready), 64'd0);
      end
      wait_done("t2", done_t);
      check("t2_err", 64'(err_len), 64'd0);
      check_writes("t2", 32'h0000_0100, 8);
      ack_delay = 1;
      @(posedge clk); #1;

      // 3: zero-length start
      start(32'h0000_0500, 16'd0);
      check("t3_done", 64'(cfg_done), 64'd1);
      check("t3_busy", 64'(cfg_busy), 64'd0);
      check("t3_tready", 64'(s_tready), 64'd0);
      check("t3_stb", 64'(wbm_stb_o), 64'd0);
      @(posedge clk); #1;
      check("t3_done_width", 64'(cfg_done), 64'd0);
      check("t3_tready_after", 64'(s_tready), 64'd0);
      repeat (3) @(posedge clk);
      #1;
      check_writes("t3", 32'h0000_0500, 0);

      // 4: tlast early on beat 2, then a 3rd beat without tlast
      start(32'h0000_0600, 16'd3);
      send_beat(32'hA1, 1'b0);
      send_beat(32'hA2, 1'b1);
      send_beat(32'hA3, 1'b0);
      wait_done("t4", done_t);
      check("t4_err_set", 64'(err_len), 64'd1);
      @(posedge clk); #1;
      check("t4_err_sticky", 64'(err_len), 64'd1);
      check_writes("t4", 32'h0000_0600, 3);
      start(32'h0000_0700, 16'd1);
      check("t4_err_cleared", 64'(err_len), 64'd0);
      send_beat(32'hB1, 1'b1);
      wait_done("t4b", done_t);
      check("t4b_err", 64'(err_len), 64'd0);
      check_writes("t4b", 32'h0000_0700, 1);
      @(posedge clk); #1;

      // 5: reset while a write awaits ack, then a late ack
      ack_en = 1'b0;
      start(32'h0000_1000, 16'd1);
      send_beat(32'h55, 1'b1);
      begin
         int n = 0;
         while (!wbm_stb_o && n < BUDGET) begin
            @(posedge clk); #1;
            n++;
         end
         check("t5_stb_pending", 64'(wbm_stb_o), 64'd1);
      end
      rst = 1'b1;
      @(posedge clk); #1;
      rst     = 1'b0;
      ack_man = 1'b1;
      check_quiet("t5_after_rst");
      @(posedge clk); #1;
      ack_man = 1'b0;
      check_quiet("t5_after_ack");
      @(posedge clk); #1;
      check("t5_no_done", 64'(cfg_done), 64'd0);
      exp_dat_q.delete();
      ack_en = 1'b1;
      start(32'h0000_2000, 16'd1);
      send_beat(32'h66, 1'b1);
      wait_done("t5", done_t);
      check_writes("t5", 32'h0000_2000, 1);
      @(posedge clk); #1;

      // 6: address wrap at 2^32 and an ignored start mid-transfer
      start(32'hFFFF_FFF8, 16'd3);
      send_beat(32'hC1, 1'b0);
      cfg_base_addr = 32'h1234_0000;
      cfg_len       = 16'd5;
      cfg_start     = 1'b1;
      @(posedge clk); #1;
      cfg_start     = 1'b0;
      check("t6_busy_kept", 64'(cfg_busy), 64'd1);
      send_beat(32'hC2, 1'b0);
      send_beat(32'hC3, 1'b1);
      wait_done("t6", done_t);
      check("t6_err", 64'(err_len), 64'd0);
      repeat (10) @(posedge clk);
      #1;
      check("t6_idle_busy", 64'(cfg_busy), 64'd0);
      check("t6_idle_tready", 64'(s_tready), 64'd0);
      check_writes("t6", 32'hFFFF_FFF8, 3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
